// File: rtl/alu_pkg.sv
// Shared ALU encodings, frame constants and the CRC-4 used to protect
// each request (operands plus opcode).
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    localparam logic FRAME_DATA = 1'b0;
    localparam logic FRAME_CMD  = 1'b1;

    localparam int unsigned N_DATA_FRAMES_DEF = 8;
    localparam int unsigned BYTE_W            = 8;
    localparam int unsigned WORD_W            = 32;
    localparam int unsigned OP_W              = 3;
    localparam int unsigned CRC_W             = 4;
    localparam int unsigned CRC_DATA_W        = 2 * WORD_W + 1 + OP_W;

    // CRC-4, polynomial x^4+x+1, data consumed MSB first.
    function automatic bit [CRC_W-1:0] crc4_calc(bit [CRC_DATA_W-1:0] d, bit [CRC_W-1:0] init);
        bit [CRC_W-1:0] c;
        bit             fb;
        c = init;
        for (int i = CRC_DATA_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ d[i];
            c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_frame_rx.sv
// Serial frame receiver: start, type, 8 payload bits MSB first, stop.
// Strobes are combinational in the stop-bit cycle so the consumer can
// register its response one cycle after the stop bit.
module alu_frame_rx
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic [BYTE_W-1:0] data_byte,
    output logic              is_cmd,
    output logic              byte_valid_c,
    output logic              frame_err_c
);

    localparam int unsigned BIT_CNT_W = $clog2(BYTE_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TYPE,
        ST_PAYLOAD,
        ST_STOP
    } rx_state_t;

    rx_state_t            state;
    logic [BIT_CNT_W-1:0] bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            data_byte <= '0;
            is_cmd    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!sin) state <= ST_TYPE;
                end
                ST_TYPE: begin
                    is_cmd  <= sin;
                    bit_cnt <= '0;
                    state   <= ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    data_byte <= {data_byte[BYTE_W-2:0], sin};
                    bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
                    if (bit_cnt == BIT_CNT_W'(BYTE_W - 1)) state <= ST_STOP;
                end
                ST_STOP: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        byte_valid_c = (state == ST_STOP) &&  sin;
        frame_err_c  = (state == ST_STOP) && !sin;
    end

endmodule

// File: rtl/alu_sin_deserializer.sv
// Reassembles {B,A} from DATA frames and decodes one checked request per
// CMD frame for the ALU core.
module alu_sin_deserializer
    import alu_pkg::*;
#(
    parameter int unsigned    N_DATA_FRAMES = N_DATA_FRAMES_DEF,
    parameter logic [CRC_W-1:0] CRC_INIT    = 4'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    output logic [WORD_W-1:0] a_out,
    output logic [WORD_W-1:0] b_out,
    output logic [OP_W-1:0]   op_out,
    output logic              out_valid,
    output logic [2:0]        err_flags,
    output logic              frame_err
);

    localparam int unsigned CNT_MAX = N_DATA_FRAMES + 1;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [BYTE_W-1:0]   data_byte;
    logic                is_cmd;
    logic                byte_valid_c;
    logic                frame_err_c;
    logic [2*WORD_W-1:0] shift_reg;
    logic [CNT_W-1:0]    data_cnt;

    logic [OP_W-1:0]     cmd_op_c;
    logic [CRC_W-1:0]    cmd_crc_c;
    logic                err_data_c;
    logic                err_crc_c;
    logic                err_op_c;

    alu_frame_rx u_frame_rx (
        .clk          (clk),
        .rst          (rst),
        .sin          (sin),
        .data_byte    (data_byte),
        .is_cmd       (is_cmd),
        .byte_valid_c (byte_valid_c),
        .frame_err_c  (frame_err_c)
    );

    function automatic logic op_is_valid(logic [OP_W-1:0] op);
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    // CMD payload is {reserved, op[2:0], crc[3:0]}; checks use the current registers.
    always_comb begin
        cmd_op_c   = data_byte[6:4];
        cmd_crc_c  = data_byte[3:0];
        err_data_c = (data_cnt != CNT_W'(N_DATA_FRAMES));
        err_crc_c  = (cmd_crc_c != crc4_calc({shift_reg, 1'b1, cmd_op_c}, CRC_INIT));
        err_op_c   = !op_is_valid(cmd_op_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            data_cnt  <= '0;
            a_out     <= '0;
            b_out     <= '0;
            op_out    <= '0;
            err_flags <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            if (frame_err_c) begin
                frame_err <= 1'b1;
                data_cnt  <= '0;
            end else if (byte_valid_c) begin
                if (is_cmd == FRAME_CMD) begin
                    out_valid <= 1'b1;
                    a_out     <= shift_reg[WORD_W-1:0];
                    b_out     <= shift_reg[2*WORD_W-1:WORD_W];
                    op_out    <= cmd_op_c;
                    err_flags <= {err_data_c, err_crc_c, err_op_c};
                    data_cnt  <= '0;
                end else begin
                    shift_reg <= {shift_reg[2*WORD_W-BYTE_W-1:0], data_byte};
                    if (data_cnt != CNT_W'(CNT_MAX)) data_cnt <= data_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/alu_sin_deserializer.md
Name: alu_sin_deserializer

Overview:
- Serial input front-end of the ALU DUT driven by the bench's send_op stimulus.
- Receives 11-bit frames on sin and reassembles operands A/B and the opcode.
- Checks the frame count, CRC-4 and opcode validity, then presents one decoded request per command frame to the ALU core.

Parameters:
N_DATA_FRAMES, 8, number of DATA frames per request (4 for B, then 4 for A)
CRC_INIT, 4'h0, CRC-4 seed value

Ports:
clk  input  1  system clock; every activity is on the rising edge
rst  input  1  reset: one clock; reset is synchronous and active-high
sin  input  1  serial input; idles at 1; one bit per clk
a_out  output  32  decoded operand A
b_out  output  32  decoded operand B
op_out  output  3  decoded opcode
out_valid  output  1  one-cycle pulse; a request is decoded
err_flags  output  3  {err_data, err_crc, err_op}; valid while out_valid=1
frame_err  output  1  one-cycle pulse; stop bit was 0

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; data-frame counter 0; shift registers 0. Reset wins over any other event, including mid-frame.
- Frame format, one bit per clk:
  - start bit 0
  - type bit: 0 = DATA, 1 = CMD
  - 8 payload bits, MSB first
  - stop bit 1
- FSM states: IDLE, TYPE, PAYLOAD, STOP.
  - IDLE -> TYPE when sin=0.
  - TYPE latches the type bit and goes to PAYLOAD.
  - PAYLOAD shifts in 8 bits under a 3-bit counter, then goes to STOP.
  - STOP samples the stop bit and returns to IDLE.
  - Back-to-back frames: a start bit is accepted in the cycle immediately after STOP.
- DATA frame with a good stop bit:
  - Byte is shifted into a 64-bit register {B,A}, first byte into B[31:24], last into A[7:0].
  - Counter increments, saturating at N_DATA_FRAMES+1.
- CMD frame with a good stop bit: payload = {1'b0, op[2:0], crc[3:0]}; the MSB is ignored.
- Error checks on a CMD frame, evaluated independently and all reported:
  - err_data = (count != N_DATA_FRAMES).
  - err_crc = (crc != crc4({B, A, 1'b1, op})). CRC-4 polynomial x^4+x+1, seed CRC_INIT, input MSB first, 68 bits.
  - err_op = op not in {AND=3'b000, OR=3'b001, ADD=3'b100, SUB=3'b101}.
  - err_crc and err_op are meaningful only when err_data=0; they are still computed on the current register contents.
- Output timing for a CMD frame:
  - out_valid=1 the cycle after its stop bit is sampled (latency 1).
  - a_out, b_out, op_out and err_flags update in that same cycle and hold until the next out_valid.
  - Counter clears to 0 in that cycle.
- Framing error (stop bit = 0):
  - frame_err pulses the next cycle.
  - Frame is discarded, counter cleared (request aborted), no out_valid.
  - FSM returns to IDLE. If sin is still 0 it is treated as a new start bit.
- More than N_DATA_FRAMES DATA frames: the register keeps the last 8 bytes, the counter saturates, and the next CMD gives err_data=1.
- sin held at 1 indefinitely: no activity, outputs hold.

Decomposition:
- Package alu_pkg (shared with tester/BFM):
  - operation_t encodings: AND 000, OR 001, ADD 100, SUB 101.
  - frame-type constants DATA=0, CMD=1.
  - N_DATA_FRAMES default.
  - function crc4_calc(bit [67:0] d, bit [3:0] init).
- One sub-module, alu_frame_rx, holds the IDLE/TYPE/PAYLOAD/STOP FSM and outputs byte[7:0], is_cmd, byte_valid and frame_err.
- The top module does assembly, counting and checks.

Test Plan:
- Send 8 DATA frames with B=32'h0000_0002, A=32'h0000_0001, then CMD with op=ADD (100) and correct CRC -> one cycle after the CMD stop bit: out_valid=1, a_out=1, b_out=2, op_out=3'b100, err_flags=3'b000.
- Same packet, CMD crc field = correct^4'h1 -> out_valid=1, err_flags=3'b010.
- Only 7 DATA frames then a correct-format CMD -> err_flags[2]=1. Next full packet with A=B=32'hFFFF_FFFF, op=OR, good CRC -> err_flags=3'b000.
- 8 DATA frames, op=3'b010 with correct CRC -> err_flags=3'b001, op_out=3'b010.
- Stop bit forced to 0 on the 3rd DATA frame -> frame_err pulse, no out_valid. A following complete good packet (A=32'h1234_5678, B=0, AND) decodes with err_flags=0.
- rst=1 for one cycle during PAYLOAD of the 5th DATA frame -> next cycle all outputs 0. A following good packet decodes correctly, with no err_data from stale count.
